usr_deserializer5: RTL and testbench
====================================

# usr_deserializer5

Serial receiver for the 5-bit universal shift register link. Consumes the serial bit stream that the register emits on its serial output and reassembles it into a parallel word, MSB-first or LSB-first, matching the register's shift-left or shift-right mode. The reassembled word is presented on a valid/ready output port with sticky overrun detection. The block sits at the far end of the serial link, feeding the downstream parallel consumer.

## Interface
- WIDTH, 5, data bits per frame (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  frame start; sampled only in IDLE
- dir  input  1  0 = MSB-first (shift-left stream), 1 = LSB-first (shift-right stream); latched at start
- SI  input  1  serial data bit
- si_en  input  1  qualifies SI; bit sampled only when high
- PO  output  WIDTH  received word
- po_valid  output  1  PO holds an unconsumed word
- po_ready  input  1  consumer accepts PO when po_valid && po_ready
- busy  output  1  frame in progress (state ≠ IDLE)
- overrun  output  1  sticky; a completed frame was dropped
- ovr_clr  input  1  synchronous clear of overrun
- perr  output  1  parity error of the word in PO (PARITY_EN only)

## Operation
- States: IDLE, SHIFT, PARITY (PARITY only with PARITY_EN).
- IDLE: start && si_en -> SI is bit 0 of the frame, count=1, dir latched, go SHIFT. start without si_en -> stays IDLE, start ignored.
- SHIFT: each cycle with si_en, one bit shifted into accumulator, count++. si_en low -> hold, no shift. start ignored.
- MSB-first: acc <= {acc[WIDTH-2:0], SI}; first bit ends in PO[WIDTH-1].
- LSB-first: acc <= {SI, acc[WIDTH-1:1]}; first bit ends in PO[0].
- After WIDTH-th bit: -> PARITY (PARITY_EN) else frame complete, -> IDLE.
- PARITY: next si_en bit is parity; frame complete, -> IDLE.
- Frame complete: if !po_valid, or po_valid && po_ready same cycle -> PO <= word, po_valid <= 1. Else word dropped, PO unchanged, overrun <= 1.
- po_valid clears on po_valid && po_ready unless a new word loads the same cycle.
- ovr_clr clears overrun; simultaneous new overrun wins (overrun stays 1).
- Back-to-back frames: start accepted in the cycle after returning to IDLE.
- Reset (any time, incl. mid-frame): state=IDLE, count=0, acc=0, PO=0, po_valid=0, busy=0, overrun=0, perr=0; partial frame discarded.

## Timing
- Bit sampled on rising edge when si_en high.
- po_valid rises the cycle after the last bit (data, or parity) is sampled; with continuous si_en, latency start -> po_valid = WIDTH cycles (WIDTH+1 with PARITY_EN).
- busy high from cycle after accepted start to cycle after last bit.
- PO stable while po_valid high and not consumed.
- overrun asserts the cycle after the dropped frame's last bit.

## Configuration
- PARITY_EN defined: frame carries one trailing even-parity bit; perr = XOR of data bits and parity bit, loaded with PO; dropped frames do not affect perr.
- PARITY_EN undefined: no PARITY state, no perr port; frame is exactly WIDTH bits.

## Structure
- Package usr_pkg: state enum (IDLE, SHIFT, PARITY), USR_WIDTH=5 default, DIR_MSB_FIRST/DIR_LSB_FIRST constants; shared with the shift register.
- Sub-module usr_bit_counter: ceil(log2(WIDTH+1))-bit counter with clear, enable, and terminal-count output; async active-low reset.

## Test plan
- MSB-first, WIDTH=5, si_en=1, SI=1,0,1,1,0 -> PO=5'b10110, po_valid at cycle 5 after start.
- LSB-first, same SI sequence -> PO=5'b01101.
- si_en toggled 1,0,1,0... during frame -> same PO, po_valid delayed by number of gap cycles; no extra bits taken.
- po_ready=0, two full frames 5'b10110 then 5'b00111 -> PO stays 5'b10110, overrun=1; ovr_clr -> overrun=0; po_ready in completion cycle -> no overrun, PO=new word.
- rst_n pulsed low after 3 bits -> all outputs 0 immediately; next frame 5'b11001 received correctly.
- PARITY_EN, data 1,0,1,1,0 + parity 1 -> PO=5'b10110, perr=0; parity 0 -> perr=1, latency 6 cycles.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the 5-bit universal shift register link (register and deserializer).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } usr_state_e;

    localparam int   USR_WIDTH     = 5;
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_bit_counter.sv
// Frame bit counter: clear has priority over enable; tc flags the last data bit position.
// Latency: count updates one cycle after clr/en; tc is combinational from the count.
// Backpressure: none; en simply holds the count when low.
module usr_bit_counter #(
    parameter int WIDTH = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // High while the bit about to be taken is the final data bit of the frame.
    assign tc = (count == LAST);

endmodule

// File: rtl/usr_deserializer5.sv
// Serial-to-parallel receiver for the USR link, MSB- or LSB-first; optional trailing even parity under PARITY_EN.
// Latency: po_valid the cycle after the last sampled bit (WIDTH cycles from start, WIDTH+1 with parity).
// Backpressure: one-word output buffer; a frame completing while PO is unconsumed is dropped and sets sticky overrun.
module usr_deserializer5
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic             SI,
    input  logic             si_en,
    output logic [WIDTH-1:0] PO,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             overrun,
`ifdef PARITY_EN
    output logic             perr,
`endif
    input  logic             ovr_clr
);

    usr_state_e       state_q, state_nxt;
    logic [WIDTH-1:0] acc_q, acc_nxt, word;
    logic             dir_q, shift_dir;
    logic             shift_en, done, tc, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start && si_en) state_nxt = SHIFT;
`ifdef PARITY_EN
            SHIFT:   if (si_en && tc) state_nxt = PARITY;
`else
            SHIFT:   if (si_en && tc) state_nxt = IDLE;
`endif
            PARITY:  if (si_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE:  shift_en = start && si_en;
            SHIFT: begin
                busy     = 1'b1;
                shift_en = si_en;
`ifndef PARITY_EN
                done     = si_en && tc;
`endif
            end
            PARITY: begin
                busy = 1'b1;
`ifdef PARITY_EN
                done = si_en;
`endif
            end
            default: ;
        endcase
    end

    usr_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (done),
        .en    (shift_en),
        .tc    (tc)
    );

    // The first bit of a frame must already follow the new direction, before dir_q is loaded.
    assign shift_dir = (state_q == IDLE) ? dir : dir_q;
    assign acc_nxt   = (shift_dir == DIR_LSB_FIRST) ? {SI, acc_q[WIDTH-1:1]}
                                                    : {acc_q[WIDTH-2:0], SI};
`ifdef PARITY_EN
    assign word = acc_q;
`else
    assign word = acc_nxt;
`endif
    assign load = done && (!po_valid || po_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else if (shift_en) begin
            acc_q <= acc_nxt;
            if (state_q == IDLE) dir_q <= dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PO       <= '0;
            po_valid <= 1'b0;
            overrun  <= 1'b0;
`ifdef PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            if (load) begin
                PO       <= word;
                po_valid <= 1'b1;
`ifdef PARITY_EN
                perr     <= (^acc_q) ^ SI;
`endif
            end else if (po_valid && po_ready) begin
                po_valid <= 1'b0;
            end
            if (done && !load)  overrun <= 1'b1;
            else if (ovr_clr)   overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usr_deserializer5.sv
// Directed bench for usr_deserializer5: both bit orders, si_en gaps, overrun, mid-frame reset, back-to-back frames.
// Builds with or without PARITY_EN.
module tb_usr_deserializer5;

    logic       clk = 1'b0;
    logic       rst_n, start, dir, SI, si_en, po_ready, ovr_clr;
    logic [4:0] PO;
    logic       po_valid, busy, overrun;
`ifdef PARITY_EN
    logic       perr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    usr_deserializer5 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dir      (dir),
        .SI       (SI),
        .si_en    (si_en),
        .PO       (PO),
        .po_valid (po_valid),
        .po_ready (po_ready),
        .busy     (busy),
        .overrun  (overrun),
`ifdef PARITY_EN
        .perr     (perr),
`endif
        .ovr_clr  (ovr_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends one frame; seq[4] goes on the wire first. Under PARITY_EN a parity bit follows,
    // correct when par_ok. Called and returns on a falling edge.
    task automatic send_frame(input logic d, input logic [4:0] seq, input bit gaps, input bit par_ok,
                              input bit rdy_last, input bit clr_last,
                              output logic vld_early, output logic busy_mid);
        logic [5:0] bits;
        int         last;
        bits = {seq, (^seq) ^ !par_ok};
`ifdef PARITY_EN
        last = 0;
`else
        last = 1;
`endif
        vld_early = 1'b0;
        busy_mid  = 1'b0;
        for (int i = 5; i >= last; i--) begin
            if (gaps && i != 5) begin
                start    = 1'b1;
                si_en    = 1'b0;
                SI       = ~bits[i];
                po_ready = 1'b0;
                @(negedge clk);
            end
            start    = (i == 5);
            dir      = (i == 5) ? d : ~d;
            si_en    = 1'b1;
            SI       = bits[i];
            po_ready = rdy_last && (i == last);
            ovr_clr  = clr_last && (i == last);
            if (i == last) vld_early = po_valid;
            @(negedge clk);
            if (i == 4) busy_mid = busy;
        end
        start    = 1'b0;
        si_en    = 1'b0;
        SI       = 1'b0;
        po_ready = 1'b0;
        ovr_clr  = 1'b0;
    endtask

    task automatic consume();
        po_ready = 1'b1;
        @(negedge clk);
        po_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
    endtask

    logic ve, bm;

    initial begin
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; SI = 1'b0;
        si_en = 1'b0; po_ready = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_po", PO, 5'b00000);
        check("rst_vld", po_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovr", overrun, 1'b0);
`ifdef PARITY_EN
        check("rst_perr", perr, 1'b0);
`endif

        // MSB-first 1,0,1,1,0
        send_frame(1'b0, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0, ve, bm);
        check("msb_vld_early", ve, 1'b0);
        check("msb_busy_mid", bm, 1'b1);
        check("msb_vld", po_valid, 1'b1);
        check("msb_po", PO, 5'b10110);
        check("msb_busy_end", busy, 1'b0);
`ifdef PARITY_EN
        check("msb_perr", perr, 1'b0);
`endif
        consume();
        check("consume_vld", po_valid, 1'b0);

        // LSB-first, same wire sequence
        send_frame(1'b1, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0, ve, bm);
        check("lsb_vld_early", ve, 1'b0);
        check("lsb_po", PO, 5'b01101);
        consume();

        // si_en gaps with inverted junk on SI and start held high
        send_frame(1'b0, 5'b10110, 1'b1, 1'b1, 1'b0, 1'b0, ve, bm);
        check("gap_vld_early", ve, 1'b0);
        check("gap_vld", po_valid, 1'b1);
        check("gap_po", PO, 5'b10110);
        consume();
        send_frame(1'b1, 5'b00111, 1'b1, 1'b1, 1'b0, 1'b0, ve, bm);
        check("gap_lsb_po", PO, 5'b11100);
        consume();

        // Overrun: second frame dropped while the first waits
        send_frame(1'b0, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0, ve, bm);
        send_frame(1'b0, 5'b00111, 1'b0, 1'b0, 1'b0, 1'b0, ve, bm);
        check("ovr_po_kept", PO, 5'b10110);
        check("ovr_vld", po_valid, 1'b1);
        check("ovr_set", overrun, 1'b1);
`ifdef PARITY_EN
        check("ovr_perr_kept", perr, 1'b0);
`endif
        pulse_clr();
        check("ovr_clr", overrun, 1'b0);
        send_frame(1'b0, 5'b00111, 1'b0, 1'b1, 1'b0, 1'b1, ve, bm);
        check("ovr_beats_clr", overrun, 1'b1);
        pulse_clr();
        check("ovr_clr2", overrun, 1'b0);
        send_frame(1'b0, 5'b00111, 1'b0, 1'b1, 1'b1, 1'b0, ve, bm);
        check("rdy_last_po", PO, 5'b00111);
        check("rdy_last_vld", po_valid, 1'b1);
        check("rdy_last_ovr", overrun, 1'b0);

        // Set overrun, then reset in the middle of a frame
        send_frame(1'b0, 5'b11100, 1'b0, 1'b1, 1'b0, 1'b0, ve, bm);
        check("pre_rst_ovr", overrun, 1'b1);
        for (int i = 0; i < 3; i++) begin
            start = (i == 0); dir = 1'b0; si_en = 1'b1; SI = 1'b1;
            @(negedge clk);
        end
        start = 1'b0; si_en = 1'b0;
        check("partial_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_po", PO, 5'b00000);
        check("mid_rst_vld", po_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(1'b0, 5'b11001, 1'b0, 1'b1, 1'b0, 1'b0, ve, bm);
        check("post_rst_vld_early", ve, 1'b0);
        check("post_rst_po", PO, 5'b11001);
        check("post_rst_vld", po_valid, 1'b1);

        // Back-to-back frames, each consumed in its completion cycle
        send_frame(1'b1, 5'b10110, 1'b0, 1'b1, 1'b1, 1'b0, ve, bm);
        check("b2b_first_po", PO, 5'b01101);
        send_frame(1'b0, 5'b00111, 1'b0, 1'b1, 1'b1, 1'b0, ve, bm);
        check("b2b_second_po", PO, 5'b00111);
        check("b2b_ovr", overrun, 1'b0);

`ifdef PARITY_EN
        consume();
        send_frame(1'b0, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0, ve, bm);
        check("par_bad_vld_early", ve, 1'b0);
        check("par_bad_po", PO, 5'b10110);
        check("par_bad_perr", perr, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
